// File: rtl/alu_exec_unit.sv
// Execution-stage ALU: single-cycle arithmetic/logic/shift ops plus iterative mul/div
// behind a start/busy/done handshake. Define ALU_SIGNED_MULDIV_EN for two's-complement mul/div.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             lt,
  output logic             gt,
  output logic             ovf,
  output logic             div_by_zero
);

  localparam int unsigned CW  = SHW + 1;
  localparam int unsigned W2  = 2 * WIDTH;
  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'b1111;
  localparam logic [3:0] OP_SUB  = 4'b1110;
  localparam logic [3:0] OP_AND  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b0001;
  localparam logic [3:0] OP_DIV  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_SLR  = 4'b1011;
  localparam logic [3:0] OP_ROL  = 4'b1000;
  localparam logic [3:0] OP_ROR  = 4'b1001;
  localparam logic [3:0] OP_ADDR = 4'b0011;
  localparam logic [3:0] OP_BCMP = 4'b0100;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hi_q, lo_q, opd_q, hi_d, lo_d, opd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_d, done_d, zero_d, lt_d, gt_d, ovf_d, dbz_d;
  logic [WIDTH-1:0] res_d, res_hi_d;

  // One shift-add step: {hi,lo} holds partial product in hi and unconsumed multiplier in lo
  function automatic logic [W2-1:0] mul_step(input logic [WIDTH-1:0] hi,
                                             input logic [WIDTH-1:0] lo,
                                             input logic [WIDTH-1:0] m);
    logic [WIDTH:0] p;
    p = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    return {p, lo[WIDTH-1:1]};
  endfunction

  // One restoring-division step: hi is the partial remainder, lo shifts dividend out / quotient in
  function automatic logic [W2-1:0] div_step(input logic [WIDTH-1:0] rem,
                                             input logic [WIDTH-1:0] quo,
                                             input logic [WIDTH-1:0] d);
    logic [WIDTH:0] r2;
    logic           qb;
    r2 = {rem, quo[WIDTH-1]};
    qb = (r2 >= {1'b0, d});
    if (qb) r2 = r2 - {1'b0, d};
    return {r2[WIDTH-1:0], quo[WIDTH-2:0], qb};
  endfunction

  // Single-cycle datapath
  logic [WIDTH-1:0] sum, diff, sc_res, sc_hi;
  logic [SHW-1:0]   sh;
  logic             sc_ovf, sc_lt, sc_gt, sc_dbz;

  assign sh   = op_b[SHW-1:0];
  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;

  always_comb begin
    sc_res = '0;
    sc_hi  = '0;
    sc_ovf = 1'b0;
    sc_lt  = 1'b0;
    sc_gt  = 1'b0;
    sc_dbz = 1'b0;
    case (alu_ctrl)
      OP_ADD, OP_ADDR: begin
        sc_res = sum;
        sc_ovf = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
      end
      OP_SUB, OP_BCMP: begin
        sc_res = diff;
        sc_ovf = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
        sc_lt  = $signed(op_a) < $signed(op_b);
        sc_gt  = $signed(op_a) > $signed(op_b);
      end
      OP_AND: sc_res = op_a & op_b;
      OP_OR:  sc_res = op_a | op_b;
      OP_SLL: sc_res = op_a << sh;
      OP_SLR: sc_res = op_a >> sh;
      OP_ROL: sc_res = WIDTH'(({op_a, op_a} << sh) >> WIDTH);
      OP_ROR: sc_res = WIDTH'({op_a, op_a} >> sh);
      OP_DIV: begin
        // only reaches the single-cycle path when the divisor is zero
        sc_res = '1;
        sc_hi  = op_a;
        sc_dbz = 1'b1;
      end
      default: ;
    endcase
  end

  // Iterative engine operands and completion values
  logic [WIDTH-1:0] mag_a, mag_b, quo, rem;
  logic [W2-1:0]    mstep, dstep, prod;
  logic             fin_ovf;

  assign mstep = mul_step(hi_q, lo_q, opd_q);
  assign dstep = div_step(hi_q, lo_q, opd_q);

`ifdef ALU_SIGNED_MULDIV_EN
  logic neg_res_q, neg_rem_q, sovf_q, neg_res_d, neg_rem_d, sovf_d;

  assign mag_a   = op_a[MSB] ? WIDTH'(-op_a) : op_a;
  assign mag_b   = op_b[MSB] ? WIDTH'(-op_b) : op_b;
  assign prod    = neg_res_q ? W2'(-mstep) : mstep;
  assign quo     = neg_res_q ? WIDTH'(-dstep[WIDTH-1:0]) : dstep[WIDTH-1:0];
  assign rem     = neg_rem_q ? WIDTH'(-dstep[W2-1:WIDTH]) : dstep[W2-1:WIDTH];
  assign fin_ovf = sovf_q;
`else
  assign mag_a   = op_a;
  assign mag_b   = op_b;
  assign prod    = mstep;
  assign quo     = dstep[WIDTH-1:0];
  assign rem     = dstep[W2-1:WIDTH];
  assign fin_ovf = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (alu_ctrl == OP_MUL)                      state_d = S_MUL;
          else if (alu_ctrl == OP_DIV && op_b != '0)   state_d = S_DIV;
        end
      end
      S_MUL, S_DIV: if (cnt_q == CW'(1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values; the first engine step folds into the launch edge
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    opd_d    = opd_q;
    cnt_d    = cnt_q;
    res_d    = result;
    res_hi_d = result_hi;
    zero_d   = zero;
    lt_d     = lt;
    gt_d     = gt;
    ovf_d    = ovf;
    dbz_d    = div_by_zero;
    done_d   = 1'b0;
    busy_d   = (state_d != S_IDLE);
`ifdef ALU_SIGNED_MULDIV_EN
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    sovf_d    = sovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (state_d == S_MUL) begin
            {hi_d, lo_d} = mul_step('0, mag_a, mag_b);
            opd_d        = mag_b;
            cnt_d        = CW'(WIDTH - 1);
          end else if (state_d == S_DIV) begin
            {hi_d, lo_d} = div_step('0, mag_a, mag_b);
            opd_d        = mag_b;
            cnt_d        = CW'(WIDTH - 1);
          end else begin
            res_d    = sc_res;
            res_hi_d = sc_hi;
            zero_d   = (sc_res == '0);
            lt_d     = sc_lt;
            gt_d     = sc_gt;
            ovf_d    = sc_ovf;
            dbz_d    = sc_dbz;
            done_d   = 1'b1;
          end
`ifdef ALU_SIGNED_MULDIV_EN
          neg_res_d = op_a[MSB] ^ op_b[MSB];
          neg_rem_d = op_a[MSB];
          sovf_d    = (op_a == {1'b1, {MSB{1'b0}}}) && (op_b == '1);
`endif
        end
      end
      S_MUL: begin
        {hi_d, lo_d} = mstep;
        cnt_d        = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          res_d    = prod[WIDTH-1:0];
          res_hi_d = prod[W2-1:WIDTH];
          zero_d   = (prod[WIDTH-1:0] == '0);
          lt_d     = 1'b0;
          gt_d     = 1'b0;
          ovf_d    = 1'b0;
          dbz_d    = 1'b0;
          done_d   = 1'b1;
        end
      end
      S_DIV: begin
        {hi_d, lo_d} = dstep;
        cnt_d        = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          res_d    = quo;
          res_hi_d = rem;
          zero_d   = (quo == '0);
          lt_d     = 1'b0;
          gt_d     = 1'b0;
          ovf_d    = fin_ovf;
          dbz_d    = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q        <= '0;
      lo_q        <= '0;
      opd_q       <= '0;
      cnt_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      result_hi   <= '0;
      zero        <= 1'b0;
      lt          <= 1'b0;
      gt          <= 1'b0;
      ovf         <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      opd_q       <= opd_d;
      cnt_q       <= cnt_d;
      busy        <= busy_d;
      done        <= done_d;
      result      <= res_d;
      result_hi   <= res_hi_d;
      zero        <= zero_d;
      lt          <= lt_d;
      gt          <= gt_d;
      ovf         <= ovf_d;
      div_by_zero <= dbz_d;
    end
  end

`ifdef ALU_SIGNED_MULDIV_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      sovf_q    <= 1'b0;
    end else begin
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      sovf_q    <= sovf_d;
    end
  end
`endif

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-stage ALU that consumes the 4-bit ALU control code and the two register operands, and produces the result and the flags.
- Single-cycle ops (add/sub/and/or/shifts/rotates, address add, branch compare) complete in one clock.
- mul uses an iterative shift-add engine; div uses an iterative restoring divider.
- A start/busy/done handshake lets the pipeline stall on the long ops.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a power of two, ≥4.
- SHW, $clog2(WIDTH), shift-amount width; taken from op_b[SHW-1:0].

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- start  input  1  request to launch the op in alu_ctrl; sampled only when busy=0.
- alu_ctrl  input  4  operation code: 1111 add, 1110 sub, 1101 and, 1100 or, 0001 mul, 0010 div, 1010 sll, 1011 slr, 1000 rol, 1001 ror, 0011 lw/sw address add, 0100 branch compare.
- op_a  input  WIDTH  first operand (rs / base).
- op_b  input  WIDTH  second operand (rt / offset / shift amount).
- busy  output  1  high while a mul/div is iterating.
- done  output  1  one-cycle pulse; result and flags valid from this cycle on.
- result  output  WIDTH  low result word, mul low product, or div quotient.
- result_hi  output  WIDTH  mul high product or div remainder; 0 for other ops.
- zero  output  1  result == 0.
- lt  output  1  signed op_a < op_b (sub and branch compare only).
- gt  output  1  signed op_a > op_b (sub and branch compare only).
- ovf  output  1  signed overflow (add, sub, address add, branch compare).
- div_by_zero  output  1  last completed op was div with op_b == 0.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low on rst.
- Reset values: all outputs 0; FSM in IDLE; iteration counter 0.
- Reset mid-operation: abandon the op immediately. No done pulse follows.
- FSM states: IDLE, MUL, DIV.
- IDLE + start + single-cycle code: at that edge, register result/result_hi/flags and set done=1 for the next cycle only. busy stays 0. Latency is 1.
- IDLE + start + mul: load the operands, counter=WIDTH, go to MUL, busy=1.
- IDLE + start + div with op_b≠0: load the operands, counter=WIDTH, go to DIV, busy=1.
- MUL/DIV: one iteration per clock, counter decrements. On the edge where the counter reaches 0: write the outputs, busy=0, done=1 for one cycle, return to IDLE.
- mul/div latency: done high exactly WIDTH cycles after the start edge. busy is high for the WIDTH-1 cycles before done.
- start while busy=1: ignored, not queued. Operand/ctrl changes while busy have no effect.
- start in the same cycle done is high: accepted normally, giving back-to-back ops.
- Output hold: outputs keep their last value between completions. done is never high two consecutive cycles for a single op.
- add / address add: result = (op_a+op_b) mod 2^WIDTH.
- sub / branch compare: result = (op_a-op_b) mod 2^WIDTH.
- ovf: standard two's-complement rule for add, sub, address add and branch compare; 0 for all other ops.
- and/or: bitwise.
- sll/slr: logical shift by op_b[SHW-1:0], zero fill.
- rol/ror: rotate by op_b[SHW-1:0]; amount 0 returns op_a.
- mul (unsigned): {result_hi,result} = op_a*op_b, 2·WIDTH bits, exact.
- div (unsigned): result = op_a/op_b, result_hi = op_a%op_b.
- div by zero: single-cycle completion (done next cycle), result = all ones, result_hi = op_a, div_by_zero=1. div_by_zero clears on the next completion.
- zero: updated on every completion from result only.
- lt/gt: updated for sub and branch compare; cleared on every other completion.
- Undefined alu_ctrl codes: single-cycle, result = 0, result_hi = 0, all flags 0 except zero=1.

Optional Feature:
- Macro: ALU_SIGNED_MULDIV_EN.
- Defined: mul/div treat the operands as two's complement.
  - Magnitudes are iterated and the sign is fixed up on the completion edge, so latency stays WIDTH.
  - Quotient truncates toward zero; remainder takes the sign of op_a.
  - Div-by-zero behaviour is unchanged.
  - Signed overflow case (most-negative / -1): result = most-negative, result_hi = 0, ovf=1.
- Undefined: mul/div are unsigned as described above, and ovf is always 0 for mul/div.

Test Plan:
- Reset/idle: assert rst=0 mid-mul (cycle 5 of 16) → busy=0, done=0, all outputs 0 immediately; no done after release.
- add overflow: ctrl=1111, a=0x7FFF, b=0x0001 → next cycle done=1, result=0x8000, ovf=1, zero=0.
- branch compare: ctrl=0100, a=0xFFFE, b=0x0003 → result=0xFFFB, lt=1, gt=0. Then a=b=0x1234 → zero=1, lt=gt=0.
- rol: ctrl=1000, a=0x8001, b=0x0004 → result=0x0018. Also ctrl=1011, a=0x8000, b=0x000F → result=0x0001.
- mul handshake: ctrl=0001, a=0xFFFF, b=0xFFFF → busy for 15 cycles, done on cycle 16, {result_hi,result}=0xFFFE_0001. A start pulsed at cycle 3 is ignored.
- div: ctrl=0010, a=100, b=7 → done at cycle 16, result=14, result_hi=2. Then b=0 → done next cycle, result=0xFFFF, result_hi=100, div_by_zero=1.
